// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm ring sequencer (ALARM_SNOOZE_EN adds snooze); in: clk, rst_n, tick_1s, adjust, alarm_on, key_stop, key_snooze, BCD time/alarm digits; out: buzzer, ringing, snoozing, ring_left
module alarm_ring_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int BEEP_DIV   = 25_000,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic [2:0] adjust,
  input  logic       alarm_on,
  input  logic       key_stop,
  input  logic       key_snooze,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic [3:0] alm_hour_h,
  input  logic [3:0] alm_hour_l,
  input  logic [3:0] alm_min_h,
  input  logic [3:0] alm_min_l,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [7:0] ring_left
);
  localparam int CW = BEEP_DIV > 1 ? $clog2(BEEP_DIV) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
  state_t state, state_n;
  logic match, match_d, trig, abort, wrap, gate, gate_n, tone, tone_n, buzzer_n;
  logic [7:0] rl_n;
  logic [CW-1:0] cnt, cnt_n;
  assign abort = !alarm_on || adjust != 3'd0;
  assign match = !abort && {hour_h, hour_l, min_h, min_l} == {alm_hour_h, alm_hour_l, alm_min_h, alm_min_l}
                 && sec_h == 4'd0 && sec_l == 4'd0;
  assign trig = match && !match_d;
  assign wrap = cnt == CW'(BEEP_DIV - 1);
`ifdef ALARM_SNOOZE_EN
  logic [9:0] snz_cnt, snz_n;
`else
  logic unused_snooze;
  assign unused_snooze = key_snooze | (SNOOZE_MIN == 0);
  assign snoozing = 1'b0;
`endif
  always_comb begin
    state_n = state;
    rl_n = ring_left;
    gate_n = gate;
    cnt_n = '0;
    tone_n = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_n = snz_cnt;
`endif
    if (abort) begin
      state_n = IDLE;
      rl_n = '0;
    end else begin
      case (state)
        IDLE: if (trig) begin
          state_n = RING;
          rl_n = 8'(RING_SEC);
          gate_n = 1'b1;
        end
        RING: begin
          cnt_n = wrap ? '0 : cnt + 1'b1;
          tone_n = tone ^ wrap;
          if (key_stop) begin
            state_n = IDLE;
            rl_n = '0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (key_snooze) begin
            state_n = SNOOZE;
            rl_n = '0;
            snz_n = 10'(SNOOZE_MIN * 60);
          end
`endif
          else if (tick_1s) begin
            state_n = ring_left > 8'd1 ? RING : IDLE;
            rl_n = ring_left > 8'd1 ? ring_left - 1'b1 : 8'd0;
            gate_n = ~gate;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: if (key_stop) begin
          state_n = IDLE;
          snz_n = '0;
        end else if (tick_1s) begin
          state_n = snz_cnt > 10'd1 ? SNOOZE : RING;
          snz_n = snz_cnt > 10'd1 ? snz_cnt - 1'b1 : 10'd0;
          rl_n = snz_cnt > 10'd1 ? ring_left : 8'(RING_SEC);
          gate_n = snz_cnt > 10'd1 ? gate : 1'b1;
        end
`endif
        default: begin
          state_n = IDLE;
          rl_n = '0;
        end
      endcase
    end
    buzzer_n = state_n == RING && tone_n && gate_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      match_d <= 1'b0;
      ring_left <= '0;
      gate <= 1'b0;
      cnt <= '0;
      tone <= 1'b0;
      buzzer <= 1'b0;
      ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= '0;
      snoozing <= 1'b0;
`endif
    end else begin
      state <= state_n;
      match_d <= match;
      ring_left <= rl_n;
      gate <= gate_n;
      cnt <= cnt_n;
      tone <= tone_n;
      buzzer <= buzzer_n;
      ringing <= state_n == RING;
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= snz_n;
      snoozing <= state_n == SNOOZE;
`endif
    end
  end
endmodule
